// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback/completion path: functional-unit codes
// and default widths, also used by the issue stage.
package writeback_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned NUM_UNITS      = 3;

  typedef enum logic [1:0] {
    FU_NONE = 2'b00,
    FU_ALU  = 2'b01,
    FU_MEM  = 2'b10,
    FU_MUL  = 2'b11
  } fu_code_t;

  // Slot index 0/1/2 (ALU/MEM/MUL) to its unit code.
  function automatic fu_code_t unit_code(input logic [1:0] idx);
    return fu_code_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/wb_holding_slot.sv
// One-entry result buffer for a functional unit; holds its payload until the
// arbiter grants it, and may be refilled on the granting edge.
module wb_holding_slot #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  capture,
  input  logic                  grant,
  input  logic [ADDR_WIDTH-1:0] in_regdest,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_writereg,
  input  logic                  in_writeov,
  input  logic                  in_overflow,
  output logic                  full,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] regdest,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  writereg,
  output logic                  writeov,
  output logic                  overflow
);

  // Capture wins over grant so a granted slot can be refilled the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full     <= 1'b0;
      regdest  <= '0;
      data     <= '0;
      writereg <= 1'b0;
      writeov  <= 1'b0;
      overflow <= 1'b0;
    end else if (capture) begin
      full     <= 1'b1;
      regdest  <= in_regdest;
      data     <= in_data;
      writereg <= in_writereg;
      writeov  <= in_writeov;
      overflow <= in_overflow;
    end else if (grant) begin
      full <= 1'b0;
    end
  end

  assign stall = full && !grant;

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: buffers one result per unit (ALU/MEM/MUL),
// grants one per cycle to the register-file write port and clears the scoreboard.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_wb_alu_valid,
  input  logic [ADDR_WIDTH-1:0] ex_wb_alu_regdest,
  input  logic [DATA_WIDTH-1:0] ex_wb_alu_data,
  input  logic                  ex_wb_alu_writereg,
  input  logic                  ex_wb_alu_writeov,
  input  logic                  ex_wb_alu_overflow,
  input  logic                  ex_wb_mem_valid,
  input  logic [ADDR_WIDTH-1:0] ex_wb_mem_regdest,
  input  logic [DATA_WIDTH-1:0] ex_wb_mem_data,
  input  logic                  ex_wb_mem_writereg,
  input  logic                  ex_wb_mem_writeov,
  input  logic                  ex_wb_mem_overflow,
  input  logic                  ex_wb_mul_valid,
  input  logic [ADDR_WIDTH-1:0] ex_wb_mul_regdest,
  input  logic [DATA_WIDTH-1:0] ex_wb_mul_data,
  input  logic                  ex_wb_mul_writereg,
  input  logic                  ex_wb_mul_writeov,
  input  logic                  ex_wb_mul_overflow,
  output logic                  wb_ex_alu_stall,
  output logic                  wb_ex_mem_stall,
  output logic                  wb_ex_mul_stall,
  output logic                  wb_rf_writereg,
  output logic [ADDR_WIDTH-1:0] wb_rf_regdest,
  output logic [DATA_WIDTH-1:0] wb_rf_data,
  output logic                  wb_sb_clear,
  output logic [ADDR_WIDTH-1:0] wb_sb_addr,
  output logic [1:0]            wb_sb_unit
);

  logic [NUM_UNITS-1:0]  in_valid, in_writereg, in_writeov, in_overflow;
  logic [NUM_UNITS-1:0]  capture, grant, full, stall;
  logic [NUM_UNITS-1:0]  slot_writereg, slot_writeov, slot_overflow;
  logic [ADDR_WIDTH-1:0] in_regdest   [NUM_UNITS];
  logic [DATA_WIDTH-1:0] in_data      [NUM_UNITS];
  logic [ADDR_WIDTH-1:0] slot_regdest [NUM_UNITS];
  logic [DATA_WIDTH-1:0] slot_data    [NUM_UNITS];

  logic [1:0] last_q;
  logic [1:0] cand;
  logic [1:0] grant_idx;
  logic       grant_valid;

  // Slot index order: 0 = ALU, 1 = MEM, 2 = MUL.
  assign in_valid    = {ex_wb_mul_valid,    ex_wb_mem_valid,    ex_wb_alu_valid};
  assign in_writereg = {ex_wb_mul_writereg, ex_wb_mem_writereg, ex_wb_alu_writereg};
  assign in_writeov  = {ex_wb_mul_writeov,  ex_wb_mem_writeov,  ex_wb_alu_writeov};
  assign in_overflow = {ex_wb_mul_overflow, ex_wb_mem_overflow, ex_wb_alu_overflow};
  assign in_regdest[0] = ex_wb_alu_regdest;
  assign in_regdest[1] = ex_wb_mem_regdest;
  assign in_regdest[2] = ex_wb_mul_regdest;
  assign in_data[0]    = ex_wb_alu_data;
  assign in_data[1]    = ex_wb_mem_data;
  assign in_data[2]    = ex_wb_mul_data;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_slot
    assign capture[u] = in_valid[u] && !stall[u];

    wb_holding_slot #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_slot (
      .clock      (clock),
      .reset      (reset),
      .capture    (capture[u]),
      .grant      (grant[u]),
      .in_regdest (in_regdest[u]),
      .in_data    (in_data[u]),
      .in_writereg(in_writereg[u]),
      .in_writeov (in_writeov[u]),
      .in_overflow(in_overflow[u]),
      .full       (full[u]),
      .stall      (stall[u]),
      .regdest    (slot_regdest[u]),
      .data       (slot_data[u]),
      .writereg   (slot_writereg[u]),
      .writeov    (slot_writeov[u]),
      .overflow   (slot_overflow[u])
    );
  end

  assign wb_ex_alu_stall = stall[0];
  assign wb_ex_mem_stall = stall[1];
  assign wb_ex_mul_stall = stall[2];

  // Round-robin search starting at the unit after the last granted one.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int unsigned k = 1; k <= NUM_UNITS; k++) begin
      cand = 2'((32'(last_q) + k) % NUM_UNITS);
      if (!grant_valid && full[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  // Registered completion outputs; address/data hold when nothing is granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q         <= 2'd2;
      wb_rf_writereg <= 1'b0;
      wb_rf_regdest  <= '0;
      wb_rf_data     <= '0;
      wb_sb_clear    <= 1'b0;
      wb_sb_addr     <= '0;
      wb_sb_unit     <= FU_NONE;
    end else if (grant_valid) begin
      last_q         <= grant_idx;
      wb_rf_writereg <= slot_writereg[grant_idx] && (slot_regdest[grant_idx] != '0)
                        && !(slot_writeov[grant_idx] && slot_overflow[grant_idx]);
      wb_rf_regdest  <= slot_regdest[grant_idx];
      wb_rf_data     <= slot_data[grant_idx];
      wb_sb_clear    <= slot_writereg[grant_idx];
      wb_sb_addr     <= slot_regdest[grant_idx];
      wb_sb_unit     <= unit_code(grant_idx);
    end else begin
      wb_rf_writereg <= 1'b0;
      wb_sb_clear    <= 1'b0;
      wb_sb_unit     <= FU_NONE;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a slot/round-robin model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_writeback_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        i_valid   [3];
  logic [4:0]  i_regdest [3];
  logic [31:0] i_data    [3];
  logic        i_wr      [3];
  logic        i_wov     [3];
  logic        i_ov      [3];

  logic        alu_stall, mem_stall, mul_stall;
  logic        rf_writereg, sb_clear;
  logic [4:0]  rf_regdest, sb_addr;
  logic [31:0] rf_data;
  logic [1:0]  sb_unit;

  int errors = 0;
  int checks = 0;

  writeback_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .ex_wb_alu_valid(i_valid[0]), .ex_wb_alu_regdest(i_regdest[0]), .ex_wb_alu_data(i_data[0]),
    .ex_wb_alu_writereg(i_wr[0]), .ex_wb_alu_writeov(i_wov[0]), .ex_wb_alu_overflow(i_ov[0]),
    .ex_wb_mem_valid(i_valid[1]), .ex_wb_mem_regdest(i_regdest[1]), .ex_wb_mem_data(i_data[1]),
    .ex_wb_mem_writereg(i_wr[1]), .ex_wb_mem_writeov(i_wov[1]), .ex_wb_mem_overflow(i_ov[1]),
    .ex_wb_mul_valid(i_valid[2]), .ex_wb_mul_regdest(i_regdest[2]), .ex_wb_mul_data(i_data[2]),
    .ex_wb_mul_writereg(i_wr[2]), .ex_wb_mul_writeov(i_wov[2]), .ex_wb_mul_overflow(i_ov[2]),
    .wb_ex_alu_stall(alu_stall), .wb_ex_mem_stall(mem_stall), .wb_ex_mul_stall(mul_stall),
    .wb_rf_writereg(rf_writereg), .wb_rf_regdest(rf_regdest), .wb_rf_data(rf_data),
    .wb_sb_clear(sb_clear), .wb_sb_addr(sb_addr), .wb_sb_unit(sb_unit)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic        m_full [3];
  logic [4:0]  m_rd   [3];
  logic [31:0] m_data [3];
  logic        m_wr   [3];
  logic        m_wov  [3];
  logic        m_ov   [3];
  int          m_last = 2;
  int          m_g;
  logic        e_wr = 1'b0, e_clr = 1'b0;
  logic [4:0]  e_rd = '0, e_addr = '0;
  logic [31:0] e_data = '0;
  logic [1:0]  e_unit = '0;

  function automatic int pick();
    for (int k = 1; k <= 3; k++) begin
      if (m_full[(m_last + k) % 3]) return (m_last + k) % 3;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 3; u++) begin
      m_full[u] = 1'b0; m_rd[u] = '0; m_data[u] = '0;
      m_wr[u] = 1'b0; m_wov[u] = 1'b0; m_ov[u] = 1'b0;
    end
    m_last = 2;
    e_wr = 1'b0; e_clr = 1'b0; e_rd = '0; e_addr = '0; e_data = '0; e_unit = 2'b00;
  endfunction

  initial model_reset();

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      m_g = pick();
      if (m_g >= 0) begin
        e_wr   = m_wr[m_g] && (m_rd[m_g] != 0) && !(m_wov[m_g] && m_ov[m_g]);
        e_clr  = m_wr[m_g];
        e_rd   = m_rd[m_g];
        e_addr = m_rd[m_g];
        e_data = m_data[m_g];
        e_unit = 2'(m_g + 1);
        m_last = m_g;
      end else begin
        e_wr = 1'b0; e_clr = 1'b0; e_unit = 2'b00;
      end
      for (int u = 0; u < 3; u++) begin
        if (i_valid[u] && !(m_full[u] && m_g != u)) begin
          m_full[u] = 1'b1; m_rd[u] = i_regdest[u]; m_data[u] = i_data[u];
          m_wr[u] = i_wr[u]; m_wov[u] = i_wov[u]; m_ov[u] = i_ov[u];
        end else if (m_g == u) begin
          m_full[u] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against model away from the active edge.
  always @(negedge clock) begin
    int g;
    g = pick();
    check("rf_writereg", 64'(rf_writereg), 64'(e_wr));
    check("rf_regdest",  64'(rf_regdest),  64'(e_rd));
    check("rf_data",     64'(rf_data),     64'(e_data));
    check("sb_clear",    64'(sb_clear),    64'(e_clr));
    check("sb_addr",     64'(sb_addr),     64'(e_addr));
    check("sb_unit",     64'(sb_unit),     64'(e_unit));
    check("alu_stall",   64'(alu_stall),   64'(m_full[0] && g != 0));
    check("mem_stall",   64'(mem_stall),   64'(m_full[1] && g != 1));
    check("mul_stall",   64'(mul_stall),   64'(m_full[2] && g != 2));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clock);
    #2;
  endtask

  task automatic clear_valid();
    for (int u = 0; u < 3; u++) i_valid[u] = 1'b0;
  endtask

  task automatic set_unit(input int u, input logic [4:0] rd, input logic [31:0] d,
                          input logic wr, input logic wov, input logic ov);
    i_valid[u] = 1'b1; i_regdest[u] = rd; i_data[u] = d;
    i_wr[u] = wr; i_wov[u] = wov; i_ov[u] = ov;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    for (int u = 0; u < 3; u++) set_unit(u, '0, '0, 1'b0, 1'b0, 1'b0);
    clear_valid();
    #1 reset = 1'b0;
    cyc();
    cyc();
    check("reset_writereg", 64'(rf_writereg), 64'd0);
    check("reset_data",     64'(rf_data),     64'd0);
    check("reset_unit",     64'(sb_unit),     64'd0);
    reset = 1'b1;
    cyc();

    // ALU only: result visible after the second edge
    set_unit(0, 5'd5, 32'h0000_00AA, 1'b1, 1'b0, 1'b0);
    cyc();
    clear_valid();
    cyc();
    check("alu_writereg", 64'(rf_writereg), 64'd1);
    check("alu_regdest",  64'(rf_regdest),  64'd5);
    check("alu_data",     64'(rf_data),     64'hAA);
    check("alu_clear",    64'(sb_clear),    64'd1);
    check("alu_addr",     64'(sb_addr),     64'd5);
    check("alu_unit",     64'(sb_unit),     64'b01);

    // All three at once after reset: ALU, MEM, MUL order
    do_reset();
    set_unit(0, 5'd1, 32'h11, 1'b1, 1'b0, 1'b0);
    set_unit(1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0);
    set_unit(2, 5'd3, 32'h33, 1'b1, 1'b0, 1'b0);
    cyc();
    clear_valid();
    check("three_alu_stall0", 64'(alu_stall), 64'd0);
    check("three_mem_stall1", 64'(mem_stall), 64'd1);
    check("three_mul_stall1", 64'(mul_stall), 64'd1);
    cyc();
    check("three_g1_unit", 64'(sb_unit), 64'b01);
    check("three_g1_rd",   64'(rf_regdest), 64'd1);
    check("three_mul_stall2", 64'(mul_stall), 64'd1);
    cyc();
    check("three_g2_unit", 64'(sb_unit), 64'b10);
    check("three_g2_data", 64'(rf_data), 64'h22);
    cyc();
    check("three_g3_unit", 64'(sb_unit), 64'b11);
    check("three_g3_rd",   64'(rf_regdest), 64'd3);
    cyc();
    check("three_idle_unit", 64'(sb_unit), 64'b00);
    check("three_idle_hold", 64'(rf_regdest), 64'd3);

    // Overflow-suppressed write still clears the scoreboard
    set_unit(0, 5'd7, 32'h77, 1'b1, 1'b1, 1'b1);
    cyc();
    clear_valid();
    cyc();
    check("ovf_writereg", 64'(rf_writereg), 64'd0);
    check("ovf_clear",    64'(sb_clear),    64'd1);
    check("ovf_addr",     64'(sb_addr),     64'd7);

    // MEM store: no write, no clear, unit code still reported
    set_unit(1, 5'd9, 32'h99, 1'b0, 1'b0, 1'b0);
    cyc();
    clear_valid();
    cyc();
    check("store_writereg", 64'(rf_writereg), 64'd0);
    check("store_clear",    64'(sb_clear),    64'd0);
    check("store_unit",     64'(sb_unit),     64'b10);
    cyc();
    check("store_unit_next", 64'(sb_unit), 64'b00);

    // Write to r0: suppressed, clear on addr 0
    set_unit(0, 5'd0, 32'h5, 1'b1, 1'b0, 1'b0);
    cyc();
    clear_valid();
    cyc();
    check("r0_writereg", 64'(rf_writereg), 64'd0);
    check("r0_clear",    64'(sb_clear),    64'd1);
    check("r0_addr",     64'(sb_addr),     64'd0);

    // ALU and MUL valid every cycle: grants alternate
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_unit(0, 5'd10, 32'(i), 1'b1, 1'b0, 1'b0);
      set_unit(2, 5'd20, 32'(100 + i), 1'b1, 1'b0, 1'b0);
      cyc();
      if (i >= 1) check("alt_unit", 64'(sb_unit), (i % 2 == 1) ? 64'b01 : 64'b11);
    end
    clear_valid();
    cyc();
    cyc();
    cyc();

    // Reset mid-operation with slots full
    set_unit(0, 5'd4, 32'h44, 1'b1, 1'b0, 1'b0);
    set_unit(1, 5'd6, 32'h66, 1'b1, 1'b0, 1'b0);
    set_unit(2, 5'd8, 32'h88, 1'b1, 1'b0, 1'b0);
    cyc();
    clear_valid();
    cyc();
    check("pre_rst_writereg", 64'(rf_writereg), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_writereg", 64'(rf_writereg), 64'd0);
    check("rst_regdest",  64'(rf_regdest),  64'd0);
    check("rst_data",     64'(rf_data),     64'd0);
    check("rst_clear",    64'(sb_clear),    64'd0);
    check("rst_unit",     64'(sb_unit),     64'd0);
    check("rst_stalls",   64'({alu_stall, mem_stall, mul_stall}), 64'd0);
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("post_rst_no_write", 64'(rf_writereg), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Completion side of the issue/scoreboard protocol. Collects results from the three functional units (ALU, MEM, MUL), buffers one result per unit, and grants one per cycle round-robin to the single register-file write port. For every granted result with a destination write, it pulses a clear to the scoreboard so the issue stage can release the register's pending bit.

## Interface
Parameters:
- DATA_WIDTH, 32, result width
- ADDR_WIDTH, 5, register address width

Ports (`<u>` ∈ {alu, mem, mul}; one set per unit):
- clock  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low
- ex_wb_<u>_valid  in  1  unit presents a result this cycle
- ex_wb_<u>_regdest  in  ADDR_WIDTH  destination register
- ex_wb_<u>_data  in  DATA_WIDTH  result value
- ex_wb_<u>_writereg  in  1  result writes a register
- ex_wb_<u>_writeov  in  1  write is suppressed on overflow
- ex_wb_<u>_overflow  in  1  unit detected overflow
- wb_ex_<u>_stall  out  1  slot full and not granted; unit must hold its result
- wb_rf_writereg  out  1  register-file write enable
- wb_rf_regdest  out  ADDR_WIDTH  register-file write address
- wb_rf_data  out  DATA_WIDTH  register-file write data
- wb_sb_clear  out  1  one-cycle scoreboard clear pulse
- wb_sb_addr  out  ADDR_WIDTH  register whose pending bit is cleared
- wb_sb_unit  out  2  unit code of the completing result: 01 ALU, 10 MEM, 11 MUL, 00 none

## Operation
- Each unit has one holding slot: full flag plus the regdest, data, writereg, writeov and overflow fields.
- Slot captures its inputs at the edge when `valid && !stall`. A full slot that is granted may be refilled at the same edge, so a unit can sustain one result per cycle when it wins arbitration every cycle.
- `wb_ex_<u>_stall = full_u && !grant_u` (combinational).
- Arbitration is round-robin among full slots. The search starts at the unit after the last-granted unit, in the order ALU → MEM → MUL → ALU. The last-granted pointer updates only on a grant. Reset pointer is MUL, so ALU has first priority after reset.
- A grant empties the slot, unless it refills at the same edge.
- The granted entry drives the registered outputs at the next edge:
  - `wb_rf_writereg = writereg && regdest != 0 && !(writeov && overflow)`
  - `wb_rf_regdest = regdest`, `wb_rf_data = data`
  - `wb_sb_clear = writereg`
  - `wb_sb_addr = regdest`, `wb_sb_unit` = granted unit code
- A result with writereg=0 (stores) is granted and consumes a cycle. It produces no write, no clear, and `wb_sb_unit` is still set.
- Overflow-suppressed writes and writes to r0 still clear the scoreboard; the issue stage set the pending bit.
- With no grant, the next edge drives `wb_rf_writereg=0`, `wb_sb_clear=0`, `wb_sb_unit=00`. Address and data fields hold their previous values.
- Two slots with the same regdest are written in grant order. Preventing WAW is the issue stage's job; this block does not check for it.

## Timing
- Reset: all slots empty, pointer = MUL.
- Reset values of outputs: `wb_rf_writereg=0`, `wb_rf_regdest=0`, `wb_rf_data=0`, `wb_sb_clear=0`, `wb_sb_addr=0`, `wb_sb_unit=00`, all stalls 0.
- Latency, best case: valid in cycle t → captured at edge t+1 → granted in cycle t+1 → outputs valid after edge t+2.
- Throughput: one completion per cycle, aggregate.
- Worst-case wait with all three slots full: 2 grants.
- Reset asserted mid-operation: buffered results are discarded, outputs return to reset values asynchronously, and stalls deassert.

## Structure
- Shared package holds the unit codes (FU_NONE=2'b00, FU_ALU=2'b01, FU_MEM=2'b10, FU_MUL=2'b11) and the width constants. The issue stage uses the same codes for `is_ex_unidadefuncional`.
- Sub-module `wb_holding_slot` is the one-entry buffer: full flag, payload, `capture`/`grant` inputs and `stall` output. It is instantiated three times.
- The top level contains the round-robin arbiter, the pointer, and the registered outputs.

## Test plan
- ALU only: regdest=5, data=0x0000_00AA, writereg=1 in cycle 0 → after edge 2, `wb_rf_writereg=1`, addr 5, data 0xAA, `wb_sb_clear=1`, `wb_sb_addr=5`, `wb_sb_unit=01`.
- All three units valid in the same cycle after reset (regdest 1, 2, 3) → grants appear on three consecutive cycles in order ALU, MEM, MUL. MEM and MUL stalls are 1 while their slot waits; none is lost.
- ALU writeov=1, overflow=1, regdest=7 → `wb_rf_writereg=0`, `wb_sb_clear=1`, `wb_sb_addr=7`.
- MEM store (writereg=0) → no write, no clear, `wb_sb_unit=10` for one cycle. Separately, regdest=0 with writereg=1 → no write, clear pulses on addr 0.
- MUL valid every cycle while ALU also valid every cycle → grants alternate ALU/MUL; neither waits more than 1 cycle.
- Reset pulled low with two slots full → all outputs 0 immediately. After release, no stale write appears.
